keypad_cntr: RTL and testbench
==============================

Name: keypad_cntr

Overview:
- Scans a 4x4 matrix keypad, debounces presses and produces a 4-bit hex key code with a one-cycle valid strobe.
- Also produces a 16-bit shift register of the last four keys, which feeds FND_cntr's fnd_value directly.
- Input-side counterpart of the multiplexed FND driver: it drives column strobes and reads rows, where the FND driver drives com strobes and writes segments.

Parameters:
- SCAN_TICKS, 100000: clk cycles per column slot (1 ms at 100 MHz); legal minimum 4.
- DEBOUNCE_TICKS, 10: consecutive stable slot ticks needed to accept a press or a release; legal minimum 1.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset_p  input  1  synchronous, active-high reset.
- row  input  4  keypad rows, active-low (0 = key closed on the currently driven column), asynchronous.
- col  output  4  column strobe, one-hot active-low.
- key_value  output  4  code of the last accepted key.
- key_valid  output  1  one-cycle pulse when a new key is accepted.
- key_pressed  output  1  high while a key is held (states PRESSED and RELEASE).
- hex_value  output  16  last four keys; newest key in [3:0].

Behaviour:
- Reset (reset_p sampled high at a clk edge):
  - state=SCAN, col=4'b1110, tick counter=0, debounce counter=0.
  - key_value=0, key_valid=0, key_pressed=0, hex_value=0.
  - Row synchronizer flops are set to 4'hF.
  - Reset mid-press aborts with no key_valid pulse; scanning resumes at column 0.
- Synchronizer: row passes through 2 flops (row_s); all decisions use row_s only.
- Tick generation:
  - Tick counter runs 0..SCAN_TICKS-1 and wraps.
  - tick=1 for the one cycle the counter equals SCAN_TICKS-1.
  - Counter free-runs in all states; col changes only on a tick.
- Column index: c = position of the 0 in col (col=1110 -> c=0, 1101 -> c=1, ...). Advancing from c=3 wraps to c=0.
- Key code: key = r*4 + c, where r is the lowest-index 0 bit of row_s. If several rows are low together, the lowest r wins.
- SCAN state, on tick:
  - If row_s != 4'hF: latch r and c, debounce counter=1, go to DEBOUNCE. col is held.
  - Else: advance the column.
- DEBOUNCE state, on tick:
  - If row_s[r]==0: counter+1.
  - If row_s[r]==1: go to SCAN with the same column (no advance) and counter=0.
  - When the counter reaches DEBOUNCE_TICKS, on that same tick: go to PRESSED, key_value=key, hex_value={hex_value[11:0],key}, key_valid=1 for exactly that cycle.
  - With DEBOUNCE_TICKS=1 the key is accepted on the SCAN tick that first detects it.
- PRESSED state:
  - col stays held; key_pressed=1.
  - On a tick with row_s[r]==1: debounce counter=1, go to RELEASE.
  - Other rows changing are ignored (no rollover).
- RELEASE state, on tick:
  - If row_s[r]==1: counter+1; when it reaches DEBOUNCE_TICKS, go to SCAN, advance the column, key_pressed=0.
  - If row_s[r]==0: go back to PRESSED with no new key_valid.
- Between ticks no state change occurs; key_valid is 0 outside its acceptance cycle.
- hex_value and key_value hold their values indefinitely. hex_value drops its oldest nibble on each accepted key.

Test Plan:
All cases use SCAN_TICKS=4 and DEBOUNCE_TICKS=3.
1. Reset, row=4'hF for 40 cycles -> col cycles 1110, 1101, 1011, 0111, 1110, changing every 4 cycles; key_valid never asserted; hex_value=0.
2. Hold key r=2, c=1 (row[2]=0 only while col==1101) for 30 ticks -> exactly one key_valid pulse; key_value=4'h9; hex_value=16'h0009; col stays 1101 while held; after release plus 3 ticks, col advances to 1011.
3. Bounce: row[0] low for 1 tick then high, while c=3 -> no key_valid; return to SCAN; col stays 0111 for that slot, then wraps to 1110.
4. Enter keys 1, 2, 3, 4, 5 in sequence (r=0 with c=1,2,3; r=1 with c=0,1) -> hex_value=16'h2345 after the fifth press; key_value=4'h5.
5. Release glitch: during RELEASE, row[r] returns low after 1 tick -> back to PRESSED; key_pressed stays 1; no second key_valid.
6. Two rows low (r=1 and r=3) on c=0 -> key_value=4'h4. Separately, assert reset_p during DEBOUNCE -> no pulse; next cycle col=1110 and all outputs are 0.

Source files
------------

// File: rtl/keypad_cntr.sv
// 4x4 matrix keypad scanner: column strobes, row synchronizer, press/release
// debounce FSM, hex key code with valid strobe and a four-key history register.
module keypad_cntr #(
  parameter int unsigned SCAN_TICKS     = 100000,
  parameter int unsigned DEBOUNCE_TICKS = 10
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic [3:0]  key_value,
  output logic        key_valid,
  output logic        key_pressed,
  output logic [15:0] hex_value
);

  localparam int unsigned TW = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_PRESSED,
    ST_RELEASE
  } state_t;

  state_t        state, state_n;
  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic [DW-1:0] deb, deb_n, deb_inc;
  logic [3:0]    col_n, col_adv;
  logic [1:0]    row_lat, row_lat_n;
  logic [1:0]    row_idx, col_idx;
  logic [3:0]    row_m, row_s;
  logic          accept;
  logic [3:0]    accept_key;

  assign tick        = (tick_cnt == TW'(SCAN_TICKS - 1));
  assign deb_inc     = deb + 1'b1;
  assign col_adv     = {col[2:0], col[3]};
  assign key_pressed = (state == ST_PRESSED) || (state == ST_RELEASE);

  // Lowest-index low row wins when several rows are closed together.
  always_comb begin
    row_idx = '0;
    for (int unsigned i = 4; i > 0; i--) begin
      if (!row_s[i-1]) row_idx = 2'(i - 1);
    end
  end

  always_comb begin
    col_idx = '0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!col[i]) col_idx = 2'(i);
    end
  end

  always_comb begin
    state_n    = state;
    deb_n      = deb;
    col_n      = col;
    row_lat_n  = row_lat;
    accept     = 1'b0;
    accept_key = {row_lat, col_idx};
    if (tick) begin
      case (state)
        ST_SCAN: begin
          if (row_s != '1) begin
            row_lat_n = row_idx;
            if (DEBOUNCE_TICKS <= 1) begin
              state_n    = ST_PRESSED;
              accept     = 1'b1;
              accept_key = {row_idx, col_idx};
              deb_n      = '0;
            end else begin
              state_n = ST_DEBOUNCE;
              deb_n   = DW'(1);
            end
          end else begin
            col_n = col_adv;
          end
        end
        ST_DEBOUNCE: begin
          if (!row_s[row_lat]) begin
            if (deb_inc == DW'(DEBOUNCE_TICKS)) begin
              state_n = ST_PRESSED;
              accept  = 1'b1;
              deb_n   = '0;
            end else begin
              deb_n = deb_inc;
            end
          end else begin
            state_n = ST_SCAN;
            deb_n   = '0;
          end
        end
        ST_PRESSED: begin
          if (row_s[row_lat]) begin
            if (DEBOUNCE_TICKS <= 1) begin
              state_n = ST_SCAN;
              col_n   = col_adv;
              deb_n   = '0;
            end else begin
              state_n = ST_RELEASE;
              deb_n   = DW'(1);
            end
          end
        end
        ST_RELEASE: begin
          if (row_s[row_lat]) begin
            if (deb_inc == DW'(DEBOUNCE_TICKS)) begin
              state_n = ST_SCAN;
              col_n   = col_adv;
              deb_n   = '0;
            end else begin
              deb_n = deb_inc;
            end
          end else begin
            state_n = ST_PRESSED;
            deb_n   = '0;
          end
        end
        default: begin
          state_n = ST_SCAN;
          deb_n   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset_p) begin
      state     <= ST_SCAN;
      tick_cnt  <= '0;
      deb       <= '0;
      col       <= 4'b1110;
      row_lat   <= '0;
      row_m     <= '1;
      row_s     <= '1;
      key_value <= '0;
      key_valid <= 1'b0;
      hex_value <= '0;
    end else begin
      state     <= state_n;
      tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
      deb       <= deb_n;
      col       <= col_n;
      row_lat   <= row_lat_n;
      row_m     <= row;
      row_s     <= row_m;
      key_valid <= accept;
      if (accept) begin
        key_value <= accept_key;
        hex_value <= {hex_value[11:0], accept_key};
      end
    end
  end

endmodule

// File: tb/tb_keypad_cntr.sv
// Directed bench for keypad_cntr with a behavioural 4x4 keypad driving the rows.
module tb_keypad_cntr;

  logic        clk = 1'b0;
  logic        reset_p;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key_value;
  logic        key_valid;
  logic        key_pressed;
  logic [15:0] hex_value;

  logic [15:0] keys = '0;
  int          checks = 0;
  int          errors = 0;
  int          valid_cnt = 0;

  keypad_cntr #(.SCAN_TICKS(4), .DEBOUNCE_TICKS(3)) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .row         (row),
    .col         (col),
    .key_value   (key_value),
    .key_valid   (key_valid),
    .key_pressed (key_pressed),
    .hex_value   (hex_value)
  );

  always #5 clk = ~clk;

  // A closed key pulls its row low only while its column is strobed.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid === 1'b1) valid_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starting at a negedge just after a tick, lands on the negedge after the n-th next tick.
  task automatic wait_ticks(input int n);
    repeat (4 * n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset_p = 1'b1;
    repeat (2) @(negedge clk);
    reset_p = 1'b0;
  endtask

  task automatic press_key(input int idx);
    int start;
    start = valid_cnt;
    keys[idx] = 1'b1;
    for (int t = 0; t < 20; t++) begin
      wait_ticks(1);
      if (valid_cnt != start) break;
    end
    check("press_valid", 16'(valid_cnt - start), 16'd1);
  endtask

  task automatic release_key(input int idx);
    keys[idx] = 1'b0;
    for (int t = 0; t < 10; t++) begin
      wait_ticks(1);
      if (key_pressed === 1'b0) break;
    end
    check("release_done", 16'(key_pressed), 16'd0);
  endtask

  logic [3:0]  col_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [15:0] hex_seq [5] = '{16'h0091, 16'h0912, 16'h9123, 16'h1234, 16'h2345};
  int          vc;
  int          bad;

  initial begin
    do_reset();
    // 1: idle scan
    check("rst_col", 16'(col), 16'h000E);
    check("rst_key_value", 16'(key_value), 16'h0);
    check("rst_key_valid", 16'(key_valid), 16'h0);
    check("rst_key_pressed", 16'(key_pressed), 16'h0);
    check("rst_hex", hex_value, 16'h0);
    for (int t = 1; t <= 10; t++) begin
      wait_ticks(1);
      check("idle_col", 16'(col), 16'(col_seq[t % 4]));
    end
    check("idle_no_valid", 16'(valid_cnt), 16'd0);
    check("idle_hex", hex_value, 16'h0);

    // 2: hold key r=2 c=1
    press_key(9);
    check("k9_value", 16'(key_value), 16'h9);
    check("k9_hex", hex_value, 16'h0009);
    bad = 0;
    for (int t = 0; t < 25; t++) begin
      wait_ticks(1);
      if (col !== 4'b1101 || key_pressed !== 1'b1) bad++;
    end
    check("k9_held", 16'(bad), 16'd0);
    check("k9_one_pulse", 16'(valid_cnt), 16'd1);
    keys[9] = 1'b0;
    wait_ticks(2);
    check("k9_rel_col_hold", 16'(col), 16'h000D);
    check("k9_rel_pressed", 16'(key_pressed), 16'd1);
    wait_ticks(1);
    check("k9_rel_col_adv", 16'(col), 16'h000B);
    check("k9_rel_done", 16'(key_pressed), 16'd0);

    // 3: one-tick bounce on c=3
    wait_ticks(1);
    check("bnc_col3", 16'(col), 16'h0007);
    keys[3] = 1'b1;
    wait_ticks(1);
    keys[3] = 1'b0;
    check("bnc_deb_col", 16'(col), 16'h0007);
    wait_ticks(1);
    check("bnc_scan_col", 16'(col), 16'h0007);
    check("bnc_not_pressed", 16'(key_pressed), 16'd0);
    wait_ticks(1);
    check("bnc_wrap", 16'(col), 16'h000E);
    check("bnc_no_valid", 16'(valid_cnt), 16'd1);

    // 4: keys 1..5
    for (int k = 1; k <= 5; k++) begin
      press_key(k);
      check("seq_hex", hex_value, hex_seq[k-1]);
      release_key(k);
    end
    check("seq_value", 16'(key_value), 16'h5);

    // 5: release glitch
    press_key(6);
    vc = valid_cnt;
    keys[6] = 1'b0;
    wait_ticks(1);
    check("gl_release_pressed", 16'(key_pressed), 16'd1);
    keys[6] = 1'b1;
    wait_ticks(1);
    check("gl_back_pressed", 16'(key_pressed), 16'd1);
    wait_ticks(3);
    check("gl_still_pressed", 16'(key_pressed), 16'd1);
    check("gl_no_second", 16'(valid_cnt), 16'(vc));
    check("gl_value", 16'(key_value), 16'h6);
    release_key(6);

    // 6: two rows on c=0, lowest row wins
    keys[12] = 1'b1;
    press_key(4);
    check("two_value", 16'(key_value), 16'h4);
    check("two_hex", hex_value, 16'h4564);
    keys[12] = 1'b0;
    release_key(4);

    // 6: reset during DEBOUNCE
    keys[0] = 1'b1;
    for (int t = 0; t < 8; t++) begin
      wait_ticks(1);
      if (col === 4'b1110) break;
    end
    check("rd_col0", 16'(col), 16'h000E);
    vc = valid_cnt;
    wait_ticks(1);
    keys[0] = 1'b0;
    do_reset();
    check("rd_col", 16'(col), 16'h000E);
    check("rd_key_value", 16'(key_value), 16'h0);
    check("rd_key_valid", 16'(key_valid), 16'h0);
    check("rd_key_pressed", 16'(key_pressed), 16'h0);
    check("rd_hex", hex_value, 16'h0);
    wait_ticks(4);
    check("rd_no_pulse", 16'(valid_cnt), 16'(vc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
